// File: rtl/fixed_point_calc_core_if.sv
// Keypad-side and display-side signal bundle of the fixed-point calculator core.
interface fixed_point_calc_core_if #(
  parameter int DATA_W = 16
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] display;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              err_div0;
  logic              overflow;

  modport master (
    output key_valid, key_code,
    input  ready, busy, display, result, result_valid, err_div0, overflow
  );

  modport slave (
    input  key_valid, key_code,
    output ready, busy, display, result, result_valid, err_div0, overflow
  );
endinterface

// File: rtl/fixed_point_calc_core.sv
// Keypad-driven signed Q(DATA_W-FRAC_W).FRAC_W calculator with a multi-cycle restoring divider.
// Define CALC_ROUND_EN for round-to-nearest (ties away from zero) on MUL and DIV.
module fixed_point_calc_core #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fixed_point_calc_core_if.slave calc
);
  localparam int W2    = 2 * DATA_W + 2;
  localparam int DIV_N = DATA_W + FRAC_W;
  localparam int CNT_W = $clog2(DIV_N + 2);
`ifdef CALC_ROUND_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_N);
  localparam logic signed [W2-1:0] HALF_W = W2'(1) <<< (FRAC_W - 1);
`else
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_N - 1);
`endif
  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_DIV = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;
  localparam logic signed [W2-1:0] MAX_W = {{(W2-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [W2-1:0] MIN_W = {{(W2-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [W2-1:0] TEN_W = W2'(10);

  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EXEC, DONE, ERROR} state_t;

  state_t                    state_reg, state_next;
  logic signed [DATA_W-1:0]  acc_reg, acc_next;
  logic signed [DATA_W-1:0]  operand_reg, operand_next;
  logic signed [DATA_W-1:0]  display_reg, display_next;
  logic signed [DATA_W-1:0]  result_reg, result_next;
  logic [3:0]                pend_reg, pend_next;
  logic [3:0]                next_key_reg, next_key_next;
  logic                      result_valid_reg, result_valid_next;
  logic                      err_div0_reg, err_div0_next;
  logic                      overflow_reg, overflow_next;
  logic [DIV_N-1:0]          div_q_reg, div_q_next;
  logic [DATA_W-1:0]         div_rem_reg, div_rem_next;
  logic [DATA_W-1:0]         div_d_reg, div_d_next;
  logic                      div_neg_reg, div_neg_next;
  logic [CNT_W-1:0]          div_cnt_reg, div_cnt_next;

  // {saturated flag, clamped value}
  function automatic logic [DATA_W:0] sat_fn(input logic signed [W2-1:0] v);
    if (v > MAX_W)      return {1'b1, MAX_W[DATA_W-1:0]};
    else if (v < MIN_W) return {1'b1, MIN_W[DATA_W-1:0]};
    else                return {1'b0, v[DATA_W-1:0]};
  endfunction

  function automatic logic signed [W2-1:0] ext_fn(input logic [DATA_W-1:0] x);
    return {{(W2-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  function automatic logic [DATA_W-1:0] mag_fn(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  logic                 ready_w, key_acc, is_digit, is_op, is_eq;
  logic signed [W2-1:0] acc_w, opd_w, key_sh_w, dig_base_w, prod_w, alu_w, q_w;
  logic [DATA_W:0]      dig_sat, exec_sat, rem_sh;
  logic [DATA_W-1:0]    rem_nx;
  logic [DIV_N-1:0]     q_nx;
  logic [DIV_N:0]       q_mag;
  logic                 div_ge, exec_done;
`ifdef CALC_ROUND_EN
  logic signed [W2-1:0] mul_mag;
`endif

  assign ready_w  = state_reg inside {ENTER_A, OP_WAIT, ENTER_B, DONE};
  assign key_acc  = calc.key_valid && ready_w;
  assign is_digit = calc.key_code <= 4'd9;
  assign is_op    = (calc.key_code >= K_ADD) && (calc.key_code <= K_DIV);
  assign is_eq    = calc.key_code == K_EQ;

  assign acc_w      = ext_fn(acc_reg);
  assign opd_w      = ext_fn(operand_reg);
  assign key_sh_w   = {{(W2-4){1'b0}}, calc.key_code} <<< FRAC_W;
  // A digit after a finished result starts a fresh operand.
  assign dig_base_w = (state_reg == DONE) ? '0 : opd_w;
  assign dig_sat    = sat_fn(dig_base_w * TEN_W + key_sh_w);
  assign prod_w     = acc_w * opd_w;

  // One restoring step: dividend bits leave the top of div_q_reg, quotient bits enter at the bottom.
  assign rem_sh = {div_rem_reg, div_q_reg[DIV_N-1]};
  assign div_ge = rem_sh >= {1'b0, div_d_reg};
  assign rem_nx = div_ge ? DATA_W'(rem_sh - {1'b0, div_d_reg}) : rem_sh[DATA_W-1:0];
  assign q_nx   = {div_q_reg[DIV_N-2:0], div_ge};

  always_comb begin
    alu_w = '0;
    q_w   = '0;
    q_mag = '0;
`ifdef CALC_ROUND_EN
    mul_mag = '0;
`endif
    case (pend_reg)
      K_ADD: alu_w = acc_w + opd_w;
      K_SUB: alu_w = acc_w - opd_w;
      K_MUL: begin
`ifdef CALC_ROUND_EN
        mul_mag = prod_w[W2-1] ? -prod_w : prod_w;
        mul_mag = (mul_mag + HALF_W) >>> FRAC_W;
        alu_w   = prod_w[W2-1] ? -mul_mag : mul_mag;
`else
        alu_w = prod_w >>> FRAC_W;
`endif
      end
      default: begin
`ifdef CALC_ROUND_EN
        q_mag = {1'b0, div_q_reg} + {{DIV_N{1'b0}}, ({div_rem_reg, 1'b0} >= {1'b0, div_d_reg})};
`else
        q_mag = {1'b0, q_nx};
`endif
        q_w   = {{(W2-DIV_N-1){1'b0}}, q_mag};
        alu_w = div_neg_reg ? -q_w : q_w;
      end
    endcase
    exec_done = (pend_reg != K_DIV) || (div_cnt_reg == DIV_LAST);
    exec_sat  = sat_fn(alu_w);
  end

  always_comb begin
    state_next        = state_reg;
    acc_next          = acc_reg;
    operand_next      = operand_reg;
    display_next      = display_reg;
    result_next       = result_reg;
    pend_next         = pend_reg;
    next_key_next     = next_key_reg;
    result_valid_next = 1'b0;
    err_div0_next     = err_div0_reg;
    overflow_next     = overflow_reg;
    div_q_next        = div_q_reg;
    div_rem_next      = div_rem_reg;
    div_d_next        = div_d_reg;
    div_neg_next      = div_neg_reg;
    div_cnt_next      = div_cnt_reg;

    if (calc.key_valid && calc.key_code == K_CLR) begin
      state_next    = ENTER_A;
      acc_next      = '0;
      operand_next  = '0;
      display_next  = '0;
      result_next   = '0;
      pend_next     = '0;
      next_key_next = '0;
      err_div0_next = 1'b0;
      overflow_next = 1'b0;
    end else begin
      case (state_reg)
        ENTER_A, OP_WAIT, DONE: if (key_acc) begin
          if (is_digit) begin
            operand_next  = dig_sat[DATA_W-1:0];
            display_next  = dig_sat[DATA_W-1:0];
            overflow_next = overflow_reg | dig_sat[DATA_W];
            if (state_reg == DONE) acc_next = '0;
            state_next = (state_reg == OP_WAIT) ? ENTER_B : ENTER_A;
          end else if (is_op) begin
            if (state_reg == ENTER_A) acc_next = operand_reg;
            else if (state_reg == DONE) acc_next = result_reg;
            pend_next    = calc.key_code;
            operand_next = '0;
            state_next   = OP_WAIT;
          end else if (is_eq) begin
            if (state_reg == ENTER_A) begin
              result_next  = operand_reg;
              display_next = operand_reg;
            end else if (state_reg == OP_WAIT) begin
              result_next  = acc_reg;
              display_next = acc_reg;
            end
            result_valid_next = 1'b1;
            state_next        = DONE;
          end
        end
        ENTER_B: if (key_acc) begin
          if (is_digit) begin
            operand_next  = dig_sat[DATA_W-1:0];
            display_next  = dig_sat[DATA_W-1:0];
            overflow_next = overflow_reg | dig_sat[DATA_W];
          end else begin
            next_key_next = calc.key_code;
            div_q_next    = {mag_fn(acc_reg), {FRAC_W{1'b0}}};
            div_rem_next  = '0;
            div_d_next    = mag_fn(operand_reg);
            div_neg_next  = acc_reg[DATA_W-1] ^ operand_reg[DATA_W-1];
            div_cnt_next  = '0;
            if (pend_reg == K_DIV && operand_reg == '0) begin
              err_div0_next = 1'b1;
              display_next  = '0;
              result_next   = '0;
              state_next    = ERROR;
            end else begin
              state_next = EXEC;
            end
          end
        end
        EXEC: begin
          div_q_next   = q_nx;
          div_rem_next = rem_nx;
          div_cnt_next = div_cnt_reg + 1'b1;
          if (exec_done) begin
            acc_next      = exec_sat[DATA_W-1:0];
            display_next  = exec_sat[DATA_W-1:0];
            overflow_next = overflow_reg | exec_sat[DATA_W];
            if (next_key_reg == K_EQ) begin
              result_next       = exec_sat[DATA_W-1:0];
              result_valid_next = 1'b1;
              state_next        = DONE;
            end else begin
              pend_next    = next_key_reg;
              operand_next = '0;
              state_next   = OP_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ENTER_A;
      acc_reg          <= '0;
      operand_reg      <= '0;
      display_reg      <= '0;
      result_reg       <= '0;
      pend_reg         <= '0;
      next_key_reg     <= '0;
      result_valid_reg <= 1'b0;
      err_div0_reg     <= 1'b0;
      overflow_reg     <= 1'b0;
      div_q_reg        <= '0;
      div_rem_reg      <= '0;
      div_d_reg        <= '0;
      div_neg_reg      <= 1'b0;
      div_cnt_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      acc_reg          <= acc_next;
      operand_reg      <= operand_next;
      display_reg      <= display_next;
      result_reg       <= result_next;
      pend_reg         <= pend_next;
      next_key_reg     <= next_key_next;
      result_valid_reg <= result_valid_next;
      err_div0_reg     <= err_div0_next;
      overflow_reg     <= overflow_next;
      div_q_reg        <= div_q_next;
      div_rem_reg      <= div_rem_next;
      div_d_reg        <= div_d_next;
      div_neg_reg      <= div_neg_next;
      div_cnt_reg      <= div_cnt_next;
    end
  end

  assign calc.ready        = ready_w;
  assign calc.busy         = state_reg == EXEC;
  assign calc.display      = display_reg;
  assign calc.result       = result_reg;
  assign calc.result_valid = result_valid_reg;
  assign calc.err_div0     = err_div0_reg;
  assign calc.overflow     = overflow_reg;
endmodule

// File: tb/tb_fixed_point_calc_core.sv
// Self-checking bench: directed key sequences plus random keys against a longint reference model.
module tb_fixed_point_calc_core;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 4;
  localparam longint SCALE = longint'(1) << FRAC_W;
  localparam longint MAXV = (longint'(1) << (DATA_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DATA_W - 1));
`ifdef CALC_ROUND_EN
  localparam int DIV_LAT = DATA_W + FRAC_W + 1;
`else
  localparam int DIV_LAT = DATA_W + FRAC_W;
`endif
  localparam int PH_A = 0, PH_OPW = 1, PH_B = 2, PH_DONE = 3, PH_ERR = 4;

  logic clk, rst_n;
  fixed_point_calc_core_if #(.DATA_W(DATA_W)) calc ();
  fixed_point_calc_core #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .calc (calc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integers in real-value units scaled by 2^FRAC_W.
  longint m_acc, m_opd, m_res, m_disp;
  int     m_pend, m_phase;
  bit     m_ovf, m_div0, m_rv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] w16(input longint v);
    return 64'(v) & 64'hFFFF;
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
    if (v < MINV) begin m_ovf = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic longint ref_op(input int op, input longint a, input longint b);
    longint p, q, r, ma, mb;
    case (op)
      10: return sat(a + b);
      11: return sat(a - b);
      12: begin
        p = a * b;
`ifdef CALC_ROUND_EN
        q = ((p < 0 ? -p : p) + SCALE / 2) / SCALE;
        return sat(p < 0 ? -q : q);
`else
        q = p / SCALE;
        if (p < 0 && (p % SCALE) != 0) q = q - 1;
        return sat(q);
`endif
      end
      default: begin
        ma = (a < 0 ? -a : a) * SCALE;
        mb = (b < 0 ? -b : b);
        q  = ma / mb;
        r  = ma % mb;
`ifdef CALC_ROUND_EN
        if (2 * r >= mb) q = q + 1;
`endif
        return sat(((a < 0) != (b < 0)) ? -q : q);
      end
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_opd = 0; m_res = 0; m_disp = 0; m_pend = 0;
    m_phase = PH_A; m_ovf = 0; m_div0 = 0; m_rv = 0;
  endtask

  task automatic model_key(input int k, output int lat);
    longint r;
    lat = 0;
    m_rv = 0;
    if (k == 15) begin model_reset(); return; end
    case (m_phase)
      PH_A, PH_OPW: begin
        if (k <= 9) begin
          m_opd = sat(m_opd * 10 + k * SCALE); m_disp = m_opd;
          if (m_phase == PH_OPW) m_phase = PH_B;
        end else if (k <= 13) begin
          if (m_phase == PH_A) m_acc = m_opd;
          m_pend = k; m_opd = 0; m_phase = PH_OPW;
        end else begin
          m_res = (m_phase == PH_A) ? m_opd : m_acc;
          m_disp = m_res; m_rv = 1; m_phase = PH_DONE;
        end
      end
      PH_B: begin
        if (k <= 9) begin
          m_opd = sat(m_opd * 10 + k * SCALE); m_disp = m_opd;
        end else if (m_pend == 13 && m_opd == 0) begin
          m_div0 = 1; m_disp = 0; m_res = 0; m_phase = PH_ERR;
        end else begin
          lat = (m_pend == 13) ? DIV_LAT : 1;
          r = ref_op(m_pend, m_acc, m_opd);
          m_acc = r; m_disp = r;
          if (k == 14) begin m_res = r; m_rv = 1; m_phase = PH_DONE; end
          else begin m_pend = k; m_opd = 0; m_phase = PH_OPW; end
        end
      end
      PH_DONE: begin
        if (k <= 9) begin
          m_acc = 0; m_opd = k * SCALE; m_disp = m_opd; m_phase = PH_A;
        end else if (k <= 13) begin
          m_acc = m_res; m_pend = k; m_opd = 0; m_phase = PH_OPW;
        end else begin
          m_rv = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_display"},  calc.display,      w16(m_disp));
    check({tag, "_result"},   calc.result,       w16(m_res));
    check({tag, "_rvalid"},   calc.result_valid, m_rv);
    check({tag, "_overflow"}, calc.overflow,     m_ovf);
    check({tag, "_div0"},     calc.err_div0,     m_div0);
    check({tag, "_ready"},    calc.ready,        m_phase != PH_ERR);
    check({tag, "_busy"},     calc.busy,         1'b0);
  endtask

  // Present one key when the core is ready, ride out any execution, then compare.
  task automatic press(input int k, input bit poke);
    int lat, nbusy, nready, w;
    w = 0;
    if (k != 15) begin
      while (calc.ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      if (calc.ready !== 1'b1) begin check("ready_wait", calc.ready, 1'b1); return; end
    end
    calc.key_valid = 1'b1;
    calc.key_code  = 4'(k);
    @(negedge clk);
    calc.key_valid = 1'b0;
    model_key(k, lat);
    nbusy = 0; nready = 0;
    while (calc.busy === 1'b1 && nbusy < 100) begin
      if (calc.ready !== 1'b0) nready++;
      nbusy++;
      calc.key_valid = poke;
      calc.key_code  = 4'($urandom_range(0, 9));
      @(negedge clk);
    end
    calc.key_valid = 1'b0;
    check("busy_cycles", 64'(nbusy), 64'(lat));
    if (lat > 0) check("ready_low_in_exec", 64'(nready), 64'd0);
    check_state($sformatf("key%0d", k));
    $display("key %2d busy=%0d display=%h result=%h rv=%b ovf=%b div0=%b",
             k, nbusy, calc.display, calc.result, calc.result_valid, calc.overflow, calc.err_div0);
    @(negedge clk);
    check("rvalid_single_pulse", calc.result_valid, 1'b0);
  endtask

  task automatic drop_key(input int k);
    calc.key_valid = 1'b1;
    calc.key_code  = 4'(k);
    @(negedge clk);
    calc.key_valid = 1'b0;
    check_state("err_drop");
    $display("key %2d dropped in error: display=%h div0=%b", k, calc.display, calc.err_div0);
  endtask

  task automatic start_exec_div();
    press(15, 0); press(5, 0); press(13, 0); press(3, 0);
    calc.key_valid = 1'b1;
    calc.key_code  = 4'd14;
    @(negedge clk);
    calc.key_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_divide", calc.busy, 1'b1);
  endtask

  initial begin
    int r, k;
    rst_n = 1'b0;
    calc.key_valid = 1'b0;
    calc.key_code  = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("reset");

    press(1, 0); press(2, 0); press(10, 0); press(3, 0); press(4, 0); press(14, 0);
    check("tp1_result", calc.result, 16'h02E0);

    press(15, 0); press(5, 0); press(11, 0); press(3, 0); press(10, 0);
    check("tp2_display_after_add", calc.display, 16'h0020);
    press(2, 0); press(14, 0);
    check("tp2_result", calc.result, 16'h0040);

    press(15, 0); press(6, 0); press(13, 0); press(3, 0); press(14, 1);
    check("tp3_div_result", calc.result, 16'h0020);
    press(12, 0); press(8, 0); press(14, 1);
    check("tp3_mul_result", calc.result, 16'h0100);
    press(14, 0);

    press(15, 0); press(2, 0); press(13, 0); press(3, 0); press(14, 0);
`ifdef CALC_ROUND_EN
    check("tp4_div_round", calc.result, 16'h000B);
`else
    check("tp4_div_trunc", calc.result, 16'h000A);
`endif

    press(15, 0); press(7, 0); press(13, 0); press(0, 0); press(14, 0);
    check("tp5_err_div0", calc.err_div0, 1'b1);
    drop_key(4);
    drop_key(14);
    press(15, 0);

    start_exec_div();
    calc.key_valid = 1'b1;
    calc.key_code  = 4'd15;
    @(negedge clk);
    calc.key_valid = 1'b0;
    model_reset();
    check_state("clear_mid_divide");

    press(15, 0); press(9, 0); press(9, 0); press(9, 0); press(9, 0);
    check("tp6_display_sat", calc.display, 16'h7FFF);
    check("tp6_overflow", calc.overflow, 1'b1);

    start_exec_div();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("reset_mid_exec");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      if (m_phase == PH_ERR) begin
        drop_key($urandom_range(0, 14));
        press(15, 0);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 55)      k = $urandom_range(0, 9);
        else if (r < 85) k = $urandom_range(10, 13);
        else if (r < 97) k = 14;
        else             k = 15;
        press(k, 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
